// File: rtl/transmissor_voltas_uart_pkg.sv
// Shared constants, FSM encoding and helpers for the lap-time UART dumper.
package transmissor_voltas_uart_pkg;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] DOT   = 8'h2E;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] QMARK = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_FINISH
  } state_e;

  // Bit period in cycles, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  // BCD nibble to printable digit; non-decimal nibbles print as '?'.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nib);
    return (nib <= 4'd9) ? (ZERO + {4'd0, nib}) : QMARK;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. ready rises on the last stop-bit cycle so a new
// byte can be accepted with no idle gap between frames.
module uart_tx_byte #(
  parameter int DIV = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic          active_q, active_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;     // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (baud_q == CW'(DIV - 1));
  assign ready_o = !active_q || (bit_end && bit_q == 4'd9);
  assign tx_o    = tx_q;

  // Baud/bit counting; the line register is updated at each bit boundary.
  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    if (valid_i && ready_o) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = 4'd0;
      sh_d     = data_i;
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd8) begin
            tx_d = 1'b1;
          end else begin
            tx_d = sh_q[0];
            sh_d = {1'b0, sh_q[7:1]};
          end
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end

  // State registers; line idles high out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      sh_q     <= 8'd0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/transmissor_voltas_uart.sv
// Walks the lap memory and prints each entry as "k:SS.CC\r\n" over UART.
module transmissor_voltas_uart
  import transmissor_voltas_uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_W      = 2
) (
  input  logic              CLOCK_50,
  input  logic              KEY_RESET,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);

  state_e            st_q, st_d;
  logic [ADDR_W-1:0] k_q, k_d;      // entry being printed
  logic [3:0]        idx_q, idx_d;  // character currently on the line
  logic [15:0]       hold_q, hold_d;
  logic              u_ready, u_valid;
  logic [7:0]        u_data;
  logic [3:0]        sel;
  logic              last_k;

  assign last_k   = (k_q == ADDR_W'(NUM_ENTRIES - 1));
  assign mem_addr = k_q;

  // State, entry counter, char index and snapshot registers.
  always_ff @(posedge CLOCK_50 or negedge KEY_RESET) begin
    if (!KEY_RESET) begin
      st_q   <= S_IDLE;
      k_q    <= '0;
      idx_q  <= 4'd0;
      hold_q <= 16'd0;
    end else begin
      st_q   <= st_d;
      k_q    <= k_d;
      idx_q  <= idx_d;
      hold_q <= hold_d;
    end
  end

  // Next state: advance one character per accepted byte, one entry per line.
  always_comb begin
    st_d   = st_q;
    k_d    = k_q;
    idx_d  = idx_q;
    hold_d = hold_q;
    case (st_q)
      S_IDLE: if (start) begin
        st_d = S_FETCH;
        k_d  = '0;
      end
      S_FETCH: st_d = S_LATCH;
      S_LATCH: begin
        hold_d = mem_data;
        idx_d  = 4'd0;
        st_d   = S_SEND;
      end
      S_SEND: if (u_ready) begin
        if (idx_q < 4'd8) begin
          idx_d = idx_q + 4'd1;
        end else if (!last_k) begin
          k_d  = k_q + 1'b1;
          st_d = S_FETCH;
        end else begin
          st_d = S_FINISH;
        end
      end
      S_FINISH: st_d = S_IDLE;
      default:  st_d = S_IDLE;
    endcase
  end

  // Outputs and character mux; the index digit needs no memory data, so the
  // first byte can launch from LATCH while the word is being captured.
  always_comb begin
    busy    = (st_q == S_FETCH) || (st_q == S_LATCH) || (st_q == S_SEND);
    done    = (st_q == S_FINISH);
    u_valid = (st_q == S_LATCH) || (st_q == S_SEND && u_ready && idx_q < 4'd8);
    sel     = (st_q == S_LATCH) ? 4'd0 : idx_q + 4'd1;
    case (sel)
      4'd0:    u_data = ZERO + 8'(k_q);
      4'd1:    u_data = COLON;
      4'd2:    u_data = bcd_to_ascii(hold_q[15:12]);
      4'd3:    u_data = bcd_to_ascii(hold_q[11:8]);
      4'd4:    u_data = DOT;
      4'd5:    u_data = bcd_to_ascii(hold_q[7:4]);
      4'd6:    u_data = bcd_to_ascii(hold_q[3:0]);
      4'd7:    u_data = CR;
      default: u_data = LF;
    endcase
  end

  uart_tx_byte #(.DIV(DIV)) u_tx (
    .clk_i   (CLOCK_50),
    .rst_ni  (KEY_RESET),
    .data_i  (u_data),
    .valid_i (u_valid),
    .ready_o (u_ready),
    .tx_o    (tx)
  );

endmodule
